serial_sub: RTL and testbench
=============================

Name: serial_sub

Overview:
- Bit-serial WIDTH-bit subtractor that computes diff = a - b, LSB first, one bit per clock.
- Each clock uses a single-bit full-subtractor cell; the borrow is registered and carried between bits.
- Feeds the one-bit subtract stage with operand bits and borrow-in, and collects its difference and borrow outputs.
- Used where area matters more than latency, e.g. narrow datapath accumulators.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start.
- b  input  WIDTH  subtrahend; captured on the accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; diff/borrow_out are valid.
- diff  output  WIDTH  result, a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow; 1 iff unsigned a < b.

Behaviour:
- State machine states: IDLE, SHIFT, DONE.
- On reset: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, internal shift registers=0, bit counter=0, borrow=0.
- IDLE with start=1 (edge E0):
  - Load a and b into shift registers.
  - Clear borrow and the bit counter.
  - Go to SHIFT.
- IDLE with start=0: hold all outputs.
- SHIFT, each edge:
  - Cell inputs are a_sh[0], b_sh[0] and borrow.
  - d = a_sh[0] ^ b_sh[0] ^ borrow.
  - next borrow = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow).
  - Shift d into the result register MSB; shift a_sh and b_sh right; increment the counter.
- When the counter equals WIDTH-1 at an edge:
  - That edge performs the final bit.
  - The result register is copied to diff and the final borrow to borrow_out.
  - The state goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency: done is high in the cycle following edge E_WIDTH, i.e. WIDTH edges after E0.
- busy=1 exactly in SHIFT.
- Back-to-back throughput is one operation per WIDTH+2 cycles.
- start while in SHIFT or DONE is ignored; it is not queued.
- a and b may change freely after E0; only the captured values are used.
- diff and borrow_out hold their last result until the next completion. They do not change on start, and do not change in SHIFT before the final edge.
- rst at any point, including mid-SHIFT or in DONE: the operation is aborted, all reset values apply on that edge, and no done pulse is produced. rst has priority over start.
- Counter width is clog2(WIDTH) bits; it never wraps within an operation.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined, an extra output port is present: ovf  output  1.
  - Signed two's-complement overflow: (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]).
  - Operand MSBs are captured at E0.
  - ovf updates on the same edge as diff, holds with it, and resets to 0.
- When undefined, the ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_sub_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2;
  - default WIDTH constant;
  - clog2 helper function for the counter width.
- One sub-module, serial_sub_bit:
  - purely combinational one-bit full-subtractor cell;
  - ports x, y, bin, d, bout;
  - instantiated once; the borrow register lives in the parent.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, start pulse -> busy=1 for 8 cycles; done in cycle 9 after E0; diff=0x1E, borrow_out=0 (ovf=0).
- a=0x00, b=0x01 -> diff=0xFF, borrow_out=1 (ovf=0).
- a=0x80, b=0x01 -> diff=0x7F, borrow_out=0; with SERIAL_SUB_OVF_EN, ovf=1. Also a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
- Start a=0x10, b=0x01, then pulse start with a=0xFF, b=0x00 at cycle 3 of SHIFT -> second request ignored; done once; diff=0x0F. Afterwards diff stays 0x0F through IDLE until the next completion.
- Assert rst at cycle 4 of SHIFT -> next cycle busy=0, done=0, diff=0x00, borrow_out=0; no done pulse follows. A fresh start then completes normally.
- Back-to-back: start held high continuously with a=0x33, b=0x11 -> done pulses every 10 cycles (WIDTH+2); diff=0x22 each time.

Source files
------------

// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and constants for the bit-serial subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Ceiling log2, floored at 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_bit
// Description : Combinational one-bit full-subtractor cell (x - y - bin).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub
// Description : Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
//               Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CW     = clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    serial_sub_bit u_bit (
        .x    (r_a_sh[0]),
        .y    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    r_res    <= w_res_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_borrow <= w_bout;
                    if (r_cnt == C_LAST) begin
                        // Counter holds at its last value so it never wraps.
                        diff       <= w_res_next;
                        borrow_out <= w_bout;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        r_state    <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        ovf        <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_sub
// Description : Self-checking bench for serial_sub against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_checks;
    int n_fail;

    logic [W-1:0] exp_diff;
    logic         exp_bo;
    logic         exp_ovf;

    serial_sub #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic check_result(input string tag);
        check_value({tag, "_diff"}, diff, exp_diff);
        check_value({tag, "_borrow"}, borrow_out, exp_bo);
`ifdef SERIAL_SUB_OVF_EN
        check_value({tag, "_ovf"}, ovf, exp_ovf);
`endif
    endtask

    // Reference: unsigned borrow from a W+1-bit subtraction, overflow from signed range.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        logic [W:0] wide;
        int         sd;
        wide     = {1'b0, ma} - {1'b0, mb};
        exp_diff = wide[W-1:0];
        exp_bo   = wide[W];
        sd       = int'($signed(ma)) - int'($signed(mb));
        exp_ovf  = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    endtask

    task automatic idle_hold(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_value("idle_no_done", done, 0);
            check_result("idle_hold");
        end
    endtask

    // One operation; poke_cycle > 0 pulses a conflicting start at that SHIFT cycle.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int poke_cycle);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cycles   = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 3 * W) begin
            if (busy === 1'b1) busy_cnt++;
            check_result("hold_in_shift");
            if (cycles == poke_cycle) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        model(ta, tb_v);
        check_value("done", done, 1);
        check_value("latency", cycles, W + 1);
        check_value("busy_cycles", busy_cnt, W);
        check_value("busy_at_done", busy, 0);
        check_result("result");
        @(negedge clk);
        check_value("done_one_cycle", done, 0);
    endtask

    initial begin
        int   pulses;
        int   last_c;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_diff = '0;
        exp_bo   = 1'b0;
        exp_ovf  = 1'b0;
        check_value("rst_busy", busy, 0);
        check_value("rst_done", done, 0);
        check_result("rst");

        run_op(8'h5A, 8'h3C, 0);
        run_op(8'h00, 8'h01, 0);
        run_op(8'h80, 8'h01, 0);
        run_op(8'h7F, 8'hFF, 0);

        // Start during SHIFT must be ignored and the result must persist in IDLE.
        run_op(8'h10, 8'h01, 3);
        check_value("ignored_start_diff", diff, 8'h0F);
        idle_hold(12);

        // Reset in the middle of SHIFT aborts without a done pulse.
        @(negedge clk);
        a = 8'h55; b = 8'h0A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_diff = '0; exp_bo = 1'b0; exp_ovf = 1'b0;
        check_value("abort_busy", busy, 0);
        check_value("abort_done", done, 0);
        check_result("abort");
        idle_hold(12);
        run_op(8'h21, 8'h43, 0);

        // Start held high: one completion every W+2 cycles.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        model(8'h33, 8'h11);
        pulses = 0;
        last_c = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                check_result("b2b");
                if (pulses == 1) check_value("b2b_first", c, W + 1);
                else             check_value("b2b_period", c - last_c, W + 2);
                last_c = c;
            end
        end
        start = 1'b0;
        check_value("b2b_pulses", pulses, 4);
        repeat (W + 4) @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
